// File: rtl/minc_prog_loader.sv
// minc_prog_loader: byte-stream loader that writes 9-bit instruction words
// into the minc program memory and holds the core in reset while loading.
// Frame: SYNC_BYTE, count N (0 = 256 words), then N pairs of HI/LO bytes.
// HI carries the op bit in bit 0 (bits 7:1 must be zero), LO the immediate.
// Optional feature macro: MINC_LOADER_CHECKSUM_EN appends a trailing checksum
// byte that must bring the 8-bit sum of count, HI and LO bytes to zero.
// RELEASE_DELAY must stay below 256.

module minc_prog_loader #(
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         RELEASE_DELAY = 2
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       cpu_nreset,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [7:0] REL_MAX = 8'(RELEASE_DELAY);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        WRITE,
`ifdef MINC_LOADER_CHECKSUM_EN
        CKSUM,
`endif
        DONE,
        ERR
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [8:0] remaining;
    logic [7:0] addr_cnt;
    logic       op;
    logic [7:0] imm;
    logic [7:0] rel_cnt;
    logic       accept;
    logic       is_sync;
`ifdef MINC_LOADER_CHECKSUM_EN
    logic [7:0] sum;
`endif

    assign accept  = rx_valid && (state != WRITE);
    assign is_sync = (rx_data == SYNC_BYTE);

    // State register; reset forces the loader back to IDLE mid-frame too
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; SYNC_BYTE only restarts outside a frame
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept && is_sync) next_state = COUNT;
            COUNT: if (accept) next_state = HI;
            HI:    if (accept) next_state = (rx_data[7:1] != 7'd0) ? ERR : LO;
            LO:    if (accept) next_state = WRITE;
            WRITE: begin
                if (remaining == 9'd1) begin
`ifdef MINC_LOADER_CHECKSUM_EN
                    next_state = CKSUM;
`else
                    next_state = DONE;
`endif
                end else begin
                    next_state = HI;
                end
            end
`ifdef MINC_LOADER_CHECKSUM_EN
            CKSUM: if (accept) next_state = ((sum + rx_data) == 8'h00) ? DONE : ERR;
`endif
            DONE:  if (accept && is_sync) next_state = COUNT;
            ERR:   if (accept && is_sync) next_state = COUNT;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: word counters, instruction fields, checksum and release timer
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            remaining <= 9'd0;
            addr_cnt  <= 8'd0;
            op        <= 1'b0;
            imm       <= 8'd0;
            rel_cnt   <= 8'd0;
`ifdef MINC_LOADER_CHECKSUM_EN
            sum       <= 8'd0;
`endif
        end else begin
            case (state)
                COUNT: if (accept) begin
                    remaining <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    addr_cnt  <= 8'd0;
`ifdef MINC_LOADER_CHECKSUM_EN
                    sum       <= sum + rx_data;
`endif
                end
                HI: if (accept) begin
                    op <= rx_data[0];
`ifdef MINC_LOADER_CHECKSUM_EN
                    sum <= sum + rx_data;
`endif
                end
                LO: if (accept) begin
                    imm <= rx_data;
`ifdef MINC_LOADER_CHECKSUM_EN
                    sum <= sum + rx_data;
`endif
                end
                WRITE: begin
                    addr_cnt  <= addr_cnt + 8'd1;
                    remaining <= remaining - 9'd1;
                end
`ifdef MINC_LOADER_CHECKSUM_EN
                IDLE, DONE, ERR: if (accept && is_sync) sum <= 8'd0;
`endif
                default: ;
            endcase

            if (state != DONE) begin
                rel_cnt <= 8'd0;
            end else if (rel_cnt < REL_MAX) begin
                rel_cnt <= rel_cnt + 8'd1;
            end
        end
    end

    // Moore outputs decoded from registered state only
    always_comb begin
        rx_ready   = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = addr_cnt;
        wr_data    = {op, imm};
        cpu_nreset = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            COUNT, HI, LO: busy = 1'b1;
            WRITE: begin
                rx_ready = 1'b0;
                wr_en    = 1'b1;
                busy     = 1'b1;
            end
`ifdef MINC_LOADER_CHECKSUM_EN
            CKSUM: busy = 1'b1;
`endif
            DONE: begin
                done       = 1'b1;
                cpu_nreset = (rel_cnt >= REL_MAX);
            end
            ERR: error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_minc_prog_loader.sv
// tb_minc_prog_loader: directed self-checking bench for minc_prog_loader.
// Default build covers the plain loader; with MINC_LOADER_CHECKSUM_EN defined
// the checksum frames are exercised instead.

module tb_minc_prog_loader;

    logic       CLK;
    logic       nRESET;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [8:0] wr_data;
    logic       cpu_nreset;
    logic       busy;
    logic       done;
    logic       error;

    int         checks   = 0;
    int         failures = 0;
    int         wrCount  = 0;
    logic [7:0] lastAddr = 8'd0;
    logic [8:0] mem [256];

    minc_prog_loader dut (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_nreset(cpu_nreset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    // Free-running clock, rising edge active
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Program memory model fed by the write port, sampled mid-cycle
    always @(negedge CLK) begin
        if (nRESET && wr_en) begin
            mem[wr_addr] = wr_data;
            wrCount++;
            lastAddr = wr_addr;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    // Offer one byte and hold it until it transfers; returns 1 time unit after the transfer edge
    task automatic applyStimulus(input logic [7:0] b);
        int waitCycles;
        waitCycles = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waitCycles < 8) begin
            stepCycle();
            waitCycles++;
        end
        if (!rx_ready) begin
            checks++;
            failures++;
            $error("[TB] FAIL rx_ready_timeout observed=0 expected=1");
        end
        stepCycle();
        rx_valid = 1'b0;
    endtask

    initial begin
        int startCount;
        int badWords;
        logic [7:0] a;

        nRESET   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #3;
        checkOutput("reset_rx_ready", rx_ready, 1);
        checkOutput("reset_wr_en", wr_en, 0);
        checkOutput("reset_wr_addr", wr_addr, 0);
        checkOutput("reset_wr_data", wr_data, 0);
        checkOutput("reset_cpu_nreset", cpu_nreset, 0);
        checkOutput("reset_flags", {busy, done, error}, 0);
        stepCycle();
        stepCycle();
        nRESET = 1'b1;
        stepCycle();

`ifdef MINC_LOADER_CHECKSUM_EN
        // Good checksum: 01+01+05+F9 wraps to zero
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h01);
        applyStimulus(8'h05);
        applyStimulus(8'hF9);
        checkOutput("ck_good_done", done, 1);
        checkOutput("ck_good_error", error, 0);
        checkOutput("ck_good_word", mem[0], 9'h105);
        stepCycle();
        stepCycle();
        checkOutput("ck_good_release", cpu_nreset, 1);

        // Bad checksum: word still written, core stays in reset
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h01);
        applyStimulus(8'h05);
        applyStimulus(8'hF8);
        checkOutput("ck_bad_error", error, 1);
        checkOutput("ck_bad_done", done, 0);
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("ck_bad_cpu_nreset", cpu_nreset, 0);
        checkOutput("ck_bad_word", mem[0], 9'h105);
        checkOutput("ck_wr_count", wrCount, 2);
`else
        // Junk bytes before sync are discarded
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        checkOutput("junk_busy", busy, 0);
        checkOutput("junk_no_write", wrCount, 0);

        // Two-word frame
        applyStimulus(8'hA5);
        checkOutput("frame_busy", busy, 1);
        applyStimulus(8'h02);
        applyStimulus(8'h01);
        applyStimulus(8'h05);
        applyStimulus(8'h00);
        applyStimulus(8'h03);
        checkOutput("frame_last_wr_en", wr_en, 1);
        checkOutput("frame_last_rx_ready", rx_ready, 0);
        stepCycle();
        checkOutput("frame_done", done, 1);
        checkOutput("frame_cpu_held", cpu_nreset, 0);
        stepCycle();
        checkOutput("frame_cpu_held2", cpu_nreset, 0);
        stepCycle();
        checkOutput("frame_cpu_release", cpu_nreset, 1);
        checkOutput("frame_word0", mem[0], 9'h105);
        checkOutput("frame_word1", mem[1], 9'h003);
        checkOutput("frame_wr_count", wrCount, 2);

        // Bad HI byte aborts the frame
        applyStimulus(8'hA5);
        checkOutput("reload_done_drop", {done, cpu_nreset}, 0);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        checkOutput("err_flag", error, 1);
        checkOutput("err_cpu", cpu_nreset, 0);
        applyStimulus(8'h33);
        checkOutput("err_ignores_byte", {error, busy}, 2'b10);
        checkOutput("err_no_write", wrCount, 2);
        applyStimulus(8'hA5);
        checkOutput("err_clears", error, 0);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'h07);
        stepCycle();
        checkOutput("recover_done", done, 1);
        checkOutput("recover_word0", mem[0], 9'h007);

        // Reset between HI and LO bytes
        startCount = wrCount;
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h01);
        nRESET = 1'b0;
        #2;
        checkOutput("midreset_outputs", {busy, done, error, wr_en, cpu_nreset}, 0);
        checkOutput("midreset_wr_data", wr_data, 0);
        checkOutput("midreset_rx_ready", rx_ready, 1);
        stepCycle();
        nRESET = 1'b1;
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'h09);
        stepCycle();
        checkOutput("midreset_one_write", wrCount - startCount, 1);
        checkOutput("midreset_addr", lastAddr, 0);
        checkOutput("midreset_word0", mem[0], 9'h009);

        // Count 0 means 256 words, data word = {addr[0], addr}
        startCount = wrCount;
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            applyStimulus({7'd0, a[0]});
            applyStimulus(a);
        end
        checkOutput("full_not_done_yet", {done, busy}, 2'b01);
        stepCycle();
        checkOutput("full_done", done, 1);
        checkOutput("full_wr_count", wrCount - startCount, 256);
        checkOutput("full_last_addr", lastAddr, 8'd255);
        badWords = 0;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            if (mem[i] !== {a[0], a}) badWords++;
        end
        checkOutput("full_contents", badWords, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/minc_prog_loader.md
Name: minc_prog_loader

Overview:
- Byte-stream program loader that writes 9-bit instruction words into the minc program memory.
- Holds the core in reset while a load is in progress and releases it when the load completes.
- Sits between a byte source (UART RX or test harness) and the program memory write port.
- Drives the core's nRESET through cpu_nreset.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- RELEASE_DELAY, 2, cycles from entering DONE until cpu_nreset goes high (0 = same cycle as done).

Ports:
- CLK  input  1  clock, rising edge.
- nRESET  input  1  asynchronous active-low reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte; a byte transfers when rx_valid & rx_ready at a CLK edge.
- wr_en  output  1  program memory write strobe, one cycle per word.
- wr_addr  output  8  write address.
- wr_data  output  9  instruction word; bit 8 = op (1 ADD, 0 LD), bits 7:0 = immediate.
- cpu_nreset  output  1  reset to the core, active-low.
- busy  output  1  frame in progress.
- done  output  1  last frame loaded successfully.
- error  output  1  last frame aborted.

Behaviour:
- Clock and reset: one clock CLK; nRESET is asynchronous and active-low.
- Output style: all outputs are Moore functions of registered state; no combinational path from rx_* to any output.
- Reset (any time, including mid-frame): state=IDLE, wr_en=0, wr_addr=0, wr_data=0, cpu_nreset=0, busy=0, done=0, error=0, rx_ready=1, internal counters 0. No partial write is issued.
- States: IDLE, COUNT, HI, LO, WRITE, CKSUM (macro only), DONE, ERR.
- rx_ready=1 in every state except WRITE.
- busy=1 in COUNT, HI, LO, WRITE, CKSUM.
- IDLE: accepted byte == SYNC_BYTE -> COUNT; any other byte is discarded.
- COUNT: accepted byte N latched into 9-bit remaining counter; N=0 means 256 words. Address counter <= 0. Go to HI.
- HI: if byte[7:1] != 0 -> ERR. Otherwise op <= byte[0], go to LO.
- LO: imm <= byte, go to WRITE.
- WRITE (exactly 1 cycle): wr_en=1, wr_addr=address counter, wr_data={op,imm}.
  - Address counter increments (8-bit wrap), remaining decrements.
  - If remaining was 1 -> CKSUM (macro defined) or DONE; otherwise -> HI.
- Latency: one word write per 3 cycles minimum (HI, LO, WRITE) with rx_valid held high.
- DONE:
  - done=1 from the first DONE cycle; release counter starts.
  - cpu_nreset=1 once RELEASE_DELAY cycles have elapsed in DONE, held thereafter.
  - Accepted SYNC_BYTE -> COUNT; done and cpu_nreset drop to 0 on the next cycle (reload).
  - Other bytes are ignored.
- ERR: error=1, cpu_nreset=0. Accepted SYNC_BYTE -> COUNT (error clears). Other bytes are ignored.
- Sync handling: a SYNC_BYTE value received inside a frame (COUNT/HI/LO) is treated as data, not as a restart.
- rx_valid low: state holds with no side effects.
- Words not written in a frame keep their previous memory contents; the loader never clears memory.

Optional Feature:
- Macro: MINC_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum covers the count byte and every HI/LO byte; it is cleared on entering COUNT.
  - After the last WRITE, the state is CKSUM; one byte is accepted there.
  - If (sum + byte) mod 256 == 0 -> DONE, else -> ERR.
  - Words already written stay written, but cpu_nreset stays 0 on ERR.
- Not defined: no CKSUM state and no sum register; the last WRITE goes directly to DONE.

Test Plan:
- Reset, then stream A5 02 01 05 00 03 (checksum macro off) -> writes {addr 0, data 0x105} and {addr 1, data 0x003}; done=1; cpu_nreset rises 2 cycles after done.
- Bytes 00 FF before A5 in IDLE -> discarded, no wr_en; the following frame loads normally.
- A5 01 02 xx -> HI byte 0x02 has bit 1 set -> ERR, error=1, no wr_en, cpu_nreset=0; then A5 01 00 07 -> addr 0 = 0x007, error=0, done=1.
- Count byte 00 with 256 words -> 256 wr_en pulses, addresses 0..255, no overflow; done after the write to address 255.
- nRESET pulsed low between the HI and LO bytes -> no write; all outputs return to reset values immediately; the next A5 frame starts from addr 0.
- Macro on, A5 01 01 05 F9 -> DONE (0x01+0x01+0x05+0xF9 = 0x100); the same frame with last byte F8 -> ERR, cpu_nreset stays 0, addr 0 written as 0x105.
